serial_addsub: RTL

Parametrised bit-serial adder/subtractor for the datapath arithmetic group. It processes `BPC` operand bits per clock, least-significant first, over `WIDTH/BPC` cycles. It uses a start/busy/done handshake and reports carry-out and signed overflow. It replaces the fixed 16-bit serial adder wherever area matters more than latency.

---
 rtl/serial_arith_pkg.sv | 14 +
 rtl/serial_addsub_if.sv | 25 ++
 rtl/serial_fa_slice.sv | 27 ++
 rtl/serial_addsub.sv | 109 ++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic group: controller states
// and the add/subtract mode encoding.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_if.sv
// Start/busy/done operand and result bundle for the bit-serial adder/subtractor.
interface serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, A, B,
        input  sum, cout, ovf, busy, done
    );

    modport slave (
        input  start, sub, A, B,
        output sum, cout, ovf, busy, done
    );

endinterface

// File: rtl/serial_fa_slice.sv
// Combinational BPC-bit ripple adder; c_msb exposes the carry into the top bit
// so the caller can derive signed overflow on the final slice.
module serial_fa_slice #(
    parameter int BPC = 1
) (
    input  logic [BPC-1:0] a,
    input  logic [BPC-1:0] b,
    input  logic           cin,
    output logic [BPC-1:0] s,
    output logic           cout,
    output logic           c_msb
);
    logic [BPC:0] chain;

    always_comb begin
        chain    = '0;
        s        = '0;
        chain[0] = cin;
        for (int i = 0; i < BPC; i++) begin
            s[i]       = a[i] ^ b[i] ^ chain[i];
            chain[i+1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
        end
        cout  = chain[BPC];
        c_msb = chain[BPC-1];
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: BPC bits per clock, LSB first, over WIDTH/BPC
// cycles, with a start/busy/done handshake, carry-out and signed overflow.
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BPC   = 1
) (
    input  logic           clk,
    input  logic           reset,
    serial_addsub_if.slave bus
);
    localparam int STEPS = WIDTH / BPC;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int IW    = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [BPC-1:0]   slice_s;
    logic             slice_cout;
    logic             slice_c_msb;
    logic [IW-1:0]    base;

    serial_fa_slice #(.BPC(BPC)) u_slice (
        .a     (a_q[BPC-1:0]),
        .b     (b_q[BPC-1:0]),
        .cin   (carry_q),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    assign base = IW'(int'(count_q) * BPC);

    // Subtraction is A + ~B + 1: B is inverted on capture and the carry seeded with 1.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.A;
                    b_d     = (bus.sub == SUB) ? ~bus.B : bus.B;
                    carry_d = (bus.sub == SUB);
                    count_d = '0;
                    sum_d   = '0;
                end
            end
            RUN: begin
                sum_d[base +: BPC] = slice_s;
                a_d     = a_q >> BPC;
                b_d     = b_q >> BPC;
                carry_d = slice_cout;
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    cout_d  = slice_cout;
                    ovf_d   = slice_c_msb ^ slice_cout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);

endmodule
